// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage: funct3 codes, FSM states,
// writeback source selects and store lane helpers.
package mem_access_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] MEM_REG_ALU  = 2'b00;
    localparam logic [1:0] MEM_REG_LOAD = 2'b01;
    localparam logic [1:0] MEM_REG_PC   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REQ      = 2'b01,
        ST_WAIT_RSP = 2'b10
    } state_t;

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_SB:   return 4'b0001 << off;
            F3_SH:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Data is replicated across lanes so the strobes alone pick the target bytes.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3)
            F3_SB:   return {4{rs2[7:0]}};
            F3_SH:   return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane extraction: picks the byte/half/word addressed by addr_lo out of the
// returned word and sign- or zero-extends it according to funct3.
module mem_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of an always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {24'd0, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives the data-memory request port, stalls upstream
// while an access is outstanding and registers the MEM/WB boundary. Optional: MEM_MISALIGN_TRAP_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_in,
    input  logic              store_in,
    input  logic              reg_write_in,
    input  logic [31:0]       opb_data_in,
    input  logic [31:0]       alu_res_in,
    input  logic [1:0]        mem_reg_in,
    input  logic [31:0]       next_sel_addr_in,
    input  logic [31:0]       pre_address_in,
    input  logic [31:0]       instruction_in,
    output logic              stall_out,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_rsp_valid,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_reg_write,
    output logic [1:0]        wb_mem_reg,
    output logic [31:0]       wb_alu_res,
    output logic [31:0]       wb_load_data,
    output logic [31:0]       wb_next_sel_addr,
    output logic [31:0]       wb_pre_address,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              wb_misalign,
`endif
    output logic [31:0]       wb_instruction
);

    state_t      state;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic        is_load;
    logic        is_store;
    logic        misalign;
    logic        mem_op;
    logic [31:0] load_data;

    assign funct3   = instruction_in[14:12];
    assign addr_lo  = alu_res_in[1:0];
    assign is_load  = load_in;
    assign is_store = store_in & ~load_in;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        if (is_load || is_store) begin
            if ((funct3 == F3_LH || (is_load && funct3 == F3_LHU)) && addr_lo[0])
                misalign = 1'b1;
            if (funct3 == F3_LW && addr_lo != 2'b00)
                misalign = 1'b1;
        end
    end
`else
    assign misalign = 1'b0;
`endif

    // Misaligned accesses never reach memory; they retire like an ALU op.
    assign mem_op = (is_load | is_store) & ~misalign;

    always_comb begin
        dmem_req_valid = 1'b0;
        stall_out      = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    dmem_req_valid = mem_op;
                    stall_out      = mem_op & ~(is_store & dmem_req_ready);
                end
                ST_REQ: begin
                    dmem_req_valid = 1'b1;
                    stall_out      = ~(is_store & dmem_req_ready);
                end
                ST_WAIT_RSP: stall_out = ~dmem_rsp_valid;
                default: ;
            endcase
        end
    end

    assign dmem_we    = dmem_req_valid & is_store;
    assign dmem_addr  = {alu_res_in[ADDR_W-1:2], 2'b00};
    assign dmem_wstrb = is_store ? store_strobe(funct3, addr_lo) : 4'b0000;
    assign dmem_wdata = store_data(funct3, opb_data_in);

    mem_load_align u_load_align (
        .funct3    (funct3),
        .addr_lo   (addr_lo),
        .rdata     (dmem_rdata),
        .load_data (load_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        if (!dmem_req_ready)
                            state <= ST_REQ;
                        else if (is_load)
                            state <= ST_WAIT_RSP;
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready)
                        state <= is_load ? ST_WAIT_RSP : ST_IDLE;
                end
                ST_WAIT_RSP: begin
                    if (dmem_rsp_valid)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A stalled edge inserts a bubble: only wb_reg_write is forced, the rest hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_reg_write     <= 1'b0;
            wb_mem_reg       <= 2'b00;
            wb_alu_res       <= 32'd0;
            wb_load_data     <= 32'd0;
            wb_next_sel_addr <= 32'd0;
            wb_pre_address   <= 32'd0;
            wb_instruction   <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            wb_misalign      <= 1'b0;
`endif
        end else if (stall_out) begin
            wb_reg_write <= 1'b0;
        end else begin
            wb_reg_write     <= reg_write_in & ~misalign;
            wb_mem_reg       <= mem_reg_in;
            wb_alu_res       <= alu_res_in;
            wb_load_data     <= (is_load && !misalign) ? load_data : 32'd0;
            wb_next_sel_addr <= next_sel_addr_in;
            wb_pre_address   <= pre_address_in;
            wb_instruction   <= instruction_in;
`ifdef MEM_MISALIGN_TRAP_EN
            wb_misalign      <= misalign;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: randomized instruction stream, a reactive
// data-memory model, and a monitor comparing each retired MEM/WB record.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              load_in, store_in, reg_write_in;
    logic [31:0]       opb_data_in, alu_res_in;
    logic [1:0]        mem_reg_in;
    logic [31:0]       next_sel_addr_in, pre_address_in, instruction_in;
    logic              stall_out, dmem_req_valid, dmem_req_ready, dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_wstrb;
    logic              dmem_rsp_valid;
    logic [31:0]       dmem_rdata;
    logic              wb_reg_write;
    logic [1:0]        wb_mem_reg;
    logic [31:0]       wb_alu_res, wb_load_data, wb_next_sel_addr, wb_pre_address, wb_instruction;
    logic              wb_misalign_obs;

`ifdef MEM_MISALIGN_TRAP_EN
    logic wb_misalign;
    assign wb_misalign_obs = wb_misalign;
`else
    assign wb_misalign_obs = 1'b0;
`endif

    mem_access_stage #(.ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .load_in          (load_in),
        .store_in         (store_in),
        .reg_write_in     (reg_write_in),
        .opb_data_in      (opb_data_in),
        .alu_res_in       (alu_res_in),
        .mem_reg_in       (mem_reg_in),
        .next_sel_addr_in (next_sel_addr_in),
        .pre_address_in   (pre_address_in),
        .instruction_in   (instruction_in),
        .stall_out        (stall_out),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_rsp_valid   (dmem_rsp_valid),
        .dmem_rdata       (dmem_rdata),
        .wb_reg_write     (wb_reg_write),
        .wb_mem_reg       (wb_mem_reg),
        .wb_alu_res       (wb_alu_res),
        .wb_load_data     (wb_load_data),
        .wb_next_sel_addr (wb_next_sel_addr),
        .wb_pre_address   (wb_pre_address),
`ifdef MEM_MISALIGN_TRAP_EN
        .wb_misalign      (wb_misalign),
`endif
        .wb_instruction   (wb_instruction)
    );

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  mem_reg;
        logic [31:0] alu_res;
        logic [31:0] load_data;
        logic [31:0] next_sel;
        logic [31:0] pre_addr;
        logic [31:0] instr;
        logic        misalign;
    } wb_t;

    wb_t         exp_q[$];
    int          n_cmp, n_err;
    int          issue_id;
    bit          abort;
    bit          cur_req, cur_store;
    logic [31:0] cur_rdata, exp_addr, exp_wdata;
    logic [3:0]  exp_strb;
    int          mem_mode;   // 0 random, 1 ready + hold response, 2 ready + fixed latency, 3 ready low

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input int off);
        if (f3 == 3'd0) return 4'(1 << off);
        if (f3 == 3'd1) return 4'(3 << (2 * (off / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        if (f3 == 3'd0) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic bit ref_misalign(input logic [2:0] f3, input int off);
        if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2) != 0) return 1'b1;
        if (f3 == 3'd2 && off != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one instruction at posedge+1 and record what it must retire as.
    task automatic issue(input bit ld, input bit st, input bit rw, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int mode);
        logic [31:0] ins;
        wb_t         e;
        bit          is_ld, is_st, mis;
        int          off;
        ins         = $urandom;
        ins[14:12]  = f3;
        is_ld       = ld;
        is_st       = st && !ld;
        off         = int'(addr[1:0]);
        mis         = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (is_ld || is_st) mis = ref_misalign(f3, off);
`endif
        rst              = 1'b0;
        load_in          = ld;
        store_in         = st;
        reg_write_in     = rw;
        opb_data_in      = rs2;
        alu_res_in       = addr;
        mem_reg_in       = 2'($urandom_range(0, 3));
        next_sel_addr_in = $urandom;
        pre_address_in   = $urandom;
        instruction_in   = ins;

        e.reg_write = rw && !mis;
        e.mem_reg   = mem_reg_in;
        e.alu_res   = addr;
        e.load_data = (is_ld && !mis) ? ref_load(f3, off, rdata) : 32'd0;
        e.next_sel  = next_sel_addr_in;
        e.pre_addr  = pre_address_in;
        e.instr     = ins;
        e.misalign  = mis;
        exp_q.push_back(e);

        cur_req   = (is_ld || is_st) && !mis;
        cur_store = is_st;
        cur_rdata = rdata;
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_strb  = ref_strb(f3, off);
        exp_wdata = ref_wdata(f3, rs2);
        mem_mode  = mode;
        issue_id++;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!stall_out) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL completion_timeout: still stalled after 64 cycles, want completion (id %0d)", issue_id);
        abort = 1'b1;
    endtask

    task automatic run_all();
        logic [2:0] f3;
        bit         ld, st;
        int         kind;
        issue(1'b0, 1'b0, 1'b1, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 2); wait_done(); if (abort) return;
        issue(1'b0, 1'b1, 1'b0, F3_SB, 32'h0000_0103, 32'h0000_00AB, 32'h0, 2); wait_done(); if (abort) return;
        issue(1'b1, 1'b0, 1'b1, F3_LB, 32'h0000_0101, $urandom, 32'h0000_80FF, 2); wait_done(); if (abort) return;
        issue(1'b1, 1'b0, 1'b1, F3_LBU, 32'h0000_0101, $urandom, 32'h0000_80FF, 2); wait_done(); if (abort) return;
        issue(1'b1, 1'b0, 1'b1, F3_LHU, 32'h0000_0302, $urandom, 32'hBEEF_1234, 2); wait_done(); if (abort) return;

        // Word load with ready withheld for three cycles.
        issue(1'b1, 1'b0, 1'b1, F3_LW, 32'h0000_0208, $urandom, 32'hCAFE_F00D, 3);
        repeat (3) @(posedge clk);
        #1;
        mem_mode = 2;
        wait_done(); if (abort) return;

        // Reset while waiting for a response; the held response then arrives stale in IDLE.
        issue(1'b1, 1'b0, 1'b1, F3_LW, 32'h0000_0200, $urandom, 32'h1111_2222, 1);
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b1;
        load_in   = 1'b0;
        store_in  = 1'b0;
        void'(exp_q.pop_back());
        cur_req   = 1'b0;
        issue_id++;
        @(posedge clk);
        #1;
        issue(1'b0, 1'b0, 1'b1, 3'd0, 32'h0000_55AA, 32'h0, 32'h0, 0); wait_done(); if (abort) return;

`ifdef MEM_MISALIGN_TRAP_EN
        issue(1'b1, 1'b0, 1'b1, F3_LW, 32'h0000_0102, $urandom, 32'h0, 0); wait_done(); if (abort) return;
`endif

        for (int k = 0; k < 300; k++) begin
            kind = $urandom_range(0, 9);
            ld   = (kind >= 3 && kind < 6) || kind == 9;
            st   = kind >= 6;
            f3   = (st && !ld) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            issue(ld, st, 1'($urandom_range(0, 1)), f3, $urandom, $urandom, $urandom, 0);
            wait_done();
            if (abort) return;
        end
    endtask

    // Data-memory model: drives ready/response at posedge+2, checks the request port at negedge.
    initial begin
        bit armed, hs_pend, rsp_now, exp_v, exp_stall;
        int wait_cnt, hs_id;
        armed = 0; hs_pend = 0; wait_cnt = 0; hs_id = -1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (hs_pend) begin
                armed    = 1;
                wait_cnt = (mem_mode == 2) ? 1 : $urandom_range(0, 2);
                hs_pend  = 0;
            end
            dmem_rsp_valid = 1'b0;
            dmem_rdata     = $urandom;
            rsp_now        = 0;
            if (armed) begin
                if (mem_mode == 1) begin
                    wait_cnt = 0;
                end else if (wait_cnt == 0) begin
                    dmem_rsp_valid = 1'b1;
                    dmem_rdata     = cur_rdata;
                    armed          = 0;
                    rsp_now        = 1;
                end else begin
                    wait_cnt--;
                end
            end else if (mem_mode == 0 && $urandom_range(0, 4) == 0) begin
                dmem_rsp_valid = 1'b1;
            end
            case (mem_mode)
                1, 2:    dmem_req_ready = 1'b1;
                3:       dmem_req_ready = 1'b0;
                default: dmem_req_ready = ($urandom_range(0, 3) != 0);
            endcase

            @(negedge clk);
            exp_v = !rst && cur_req && (hs_id != issue_id);
            check("dmem_req_valid", dmem_req_valid, exp_v);
            if (exp_v && dmem_req_valid) begin
                check("dmem_we", dmem_we, cur_store);
                check("dmem_addr", dmem_addr, exp_addr[ADDR_W-1:0]);
                if (cur_store) begin
                    check("dmem_wstrb", dmem_wstrb, exp_strb);
                    check("dmem_wdata", dmem_wdata, exp_wdata);
                end
            end
            if (rst || !cur_req)
                exp_stall = 0;
            else if (hs_id != issue_id)
                exp_stall = !(dmem_req_ready && cur_store);
            else
                exp_stall = !rsp_now;
            check("stall_out", stall_out, exp_stall);
            if (exp_v && dmem_req_ready) begin
                hs_id = issue_id;
                if (!cur_store) hs_pend = 1;
            end
        end
    end

    // Monitor: classifies each edge from pre-edge stall/rst, then checks the wb record after it.
    initial begin
        int  pending;   // 0 none, 1 reset, 2 bubble, 3 capture
        wb_t obs, e;
        pending = 0;
        forever begin
            @(negedge clk);
            obs = {wb_reg_write, wb_mem_reg, wb_alu_res, wb_load_data,
                   wb_next_sel_addr, wb_pre_address, wb_instruction, wb_misalign_obs};
            case (pending)
                1: check("reset_wb", obs, '0);
                2: check("bubble_reg_write", wb_reg_write, 1'b0);
                3: begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_retire: got %0h want nothing at %0t", obs, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_record", obs, e);
                    end
                end
                default: ;
            endcase
            pending = rst ? 1 : (stall_out ? 2 : 3);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0; issue_id = 0; abort = 0;
        cur_req = 0; cur_store = 0; cur_rdata = 0; mem_mode = 0;
        exp_addr = 0; exp_wdata = 0; exp_strb = 0;
        rst = 1'b1;
        load_in = 0; store_in = 0; reg_write_in = 0;
        opb_data_in = 0; alu_res_in = 0; mem_reg_in = 0;
        next_sel_addr_in = 0; pre_address_in = 0; instruction_in = 0;
        repeat (3) @(posedge clk);
        #1;
        run_all();
        rst      = 1'b1;
        load_in  = 1'b0;
        store_in = 1'b0;
        cur_req  = 1'b0;
        issue_id++;
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
